// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Receives a boot image over a byte stream, writes it word by word into
// instruction memory and holds the processor datapath in reset until the
// complete image has arrived and its checksum has matched.
//
// Frame: N (16-bit, LE) | 4N payload bytes (words LE) | XOR of payload bytes
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   rx_valid     in   byte-stream valid
//   rx_data      in   byte-stream data [7:0]
//   rx_ready     out  loader accepts a byte (transfer on valid & ready)
//   reload       in   synchronous pulse: abandon everything, await new frame
//   imem_we      out  one-cycle instruction-memory write strobe
//   imem_addr    out  instruction-memory byte address [31:0]
//   imem_wdata   out  instruction-memory write word [31:0]
//   core_reset_n out  active-low datapath reset, released only after DONE
//   load_done    out  image loaded and verified
//   load_error   out  frame rejected (bad header, checksum or timeout)
module imem_boot_loader #(
  parameter int unsigned MAX_WORDS      = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset_n,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  // The idle counter reaches TIMEOUT_CYCLES on the edge where it is at this value.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    HDR_LO   = 3'd0,
    HDR_HI   = 3'd1,
    PAYLOAD  = 3'd2,
    CHECKSUM = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [15:0]         word_idx_q, word_idx_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         word_q, word_d;
  logic [7:0]          csum_q, csum_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                imem_we_q, imem_we_d;
  logic [31:0]         imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                core_reset_n_q, core_reset_n_d;
  logic                load_done_q, load_done_d;
  logic                load_error_q, load_error_d;

  logic                accept;
  logic [15:0]         hdr_n;
  logic                last_word;
  logic                in_frame;

  assign rx_ready  = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                     (state_q == PAYLOAD) || (state_q == CHECKSUM);
  assign accept    = rx_valid && rx_ready;
  // Full word count as it will be once the high header byte lands.
  assign hdr_n     = {rx_data, count_q[7:0]};
  assign last_word = (word_idx_q == (count_q - 16'd1));
  assign in_frame  = (state_q == HDR_HI) || (state_q == PAYLOAD) ||
                     (state_q == CHECKSUM);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    csum_d       = csum_q;
    idle_d       = idle_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (reload) begin
      // Reload wins over any byte presented in the same cycle.
      state_d    = HDR_LO;
      count_d    = '0;
      word_idx_d = '0;
      byte_idx_d = '0;
      word_d     = '0;
      csum_d     = '0;
      idle_d     = '0;
    end else begin
      case (state_q)
        HDR_LO: begin
          if (accept) begin
            count_d    = {8'h00, rx_data};
            word_idx_d = '0;
            byte_idx_d = '0;
            csum_d     = '0;
            state_d    = HDR_HI;
          end
        end
        HDR_HI: begin
          if (accept) begin
            count_d = hdr_n;
            if ((hdr_n == 16'd0) || (32'(hdr_n) > MAX_WORDS)) begin
              state_d = ERROR;
            end else begin
              state_d = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (accept) begin
            csum_d     = csum_q ^ rx_data;
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_d[7:0]   = rx_data;
              2'd1: word_d[15:8]  = rx_data;
              2'd2: word_d[23:16] = rx_data;
              default: begin
                // Fourth byte completes the word: write it on the next cycle.
                imem_we_d    = 1'b1;
                imem_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                imem_wdata_d = {rx_data, word_q};
                word_idx_d   = word_idx_q + 16'd1;
                if (last_word) begin
                  state_d = CHECKSUM;
                end
              end
            endcase
          end
        end
        CHECKSUM: begin
          if (accept) begin
            state_d = (rx_data == csum_q) ? DONE : ERROR;
          end
        end
        default: begin
          // DONE and ERROR are left only through reload or reset_n.
        end
      endcase

      // Inter-byte watchdog; it never runs while waiting for a frame to start.
      if (in_frame) begin
        if (accept) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + 1'b1;
          if (idle_q == IDLE_LAST) begin
            state_d = ERROR;
          end
        end
      end else begin
        idle_d = '0;
      end
    end

    // core_reset_n lags DONE by one cycle so the last write has settled.
    core_reset_n_d = (state_q == DONE) && !reload;
    load_done_d    = (state_d == DONE);
    load_error_d   = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= HDR_LO;
      count_q        <= '0;
      word_idx_q     <= '0;
      byte_idx_q     <= '0;
      word_q         <= '0;
      csum_q         <= '0;
      idle_q         <= '0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= BASE_ADDR;
      imem_wdata_q   <= '0;
      core_reset_n_q <= 1'b0;
      load_done_q    <= 1'b0;
      load_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      word_idx_q     <= word_idx_d;
      byte_idx_q     <= byte_idx_d;
      word_q         <= word_d;
      csum_q         <= csum_d;
      idle_q         <= idle_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      core_reset_n_q <= core_reset_n_d;
      load_done_q    <= load_done_d;
      load_error_q   <= load_error_d;
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_reset_n = core_reset_n_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader. Two instances share one byte stream and
// differ only in BASE_ADDR (0x0 and 0x100); both use a 16-cycle timeout.
module tb_imem_boot_loader;

  localparam int MAXW = 256;
  localparam int TO   = 16;

  localparam int M_HDR  = 0;  // waiting for first header byte
  localparam int M_RUN  = 1;  // inside a frame
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  logic        clk;
  logic        reset_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        reload;

  logic        rx_ready0, imem_we0, core_rn0, done0, err0;
  logic [31:0] imem_addr0, imem_wdata0;
  logic        rx_ready1, imem_we1, core_rn1, done1, err1;
  logic [31:0] imem_addr1, imem_wdata1;

  int checks   = 0;
  int failures = 0;

  logic [63:0] wlog0[$];
  logic [63:0] wlog1[$];

  imem_boot_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(32'h0000_0000), .TIMEOUT_CYCLES(TO)) dut0 (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready0), .reload(reload), .imem_we(imem_we0), .imem_addr(imem_addr0),
    .imem_wdata(imem_wdata0), .core_reset_n(core_rn0), .load_done(done0), .load_error(err0)
  );

  imem_boot_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(32'h0000_0100), .TIMEOUT_CYCLES(TO)) dut1 (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready1), .reload(reload), .imem_we(imem_we1), .imem_addr(imem_addr1),
    .imem_wdata(imem_wdata1), .core_reset_n(core_rn1), .load_done(done1), .load_error(err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural frame model ----------------
  // Tracks the frame as "position of the next byte" plus the bytes seen.
  typedef struct {
    int          st;
    int          pos;
    int          n;
    int          idle;
    logic [7:0]  x;
    logic [7:0]  b0, b1, b2;
    logic        we;
    logic [31:0] off;
    logic [31:0] wd;
    logic        rn;
    logic        done;
    logic        err;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r.st = M_HDR; r.pos = 0; r.n = 0; r.idle = 0; r.x = 8'h00;
    r.b0 = 8'h00; r.b1 = 8'h00; r.b2 = 8'h00;
    r.we = 1'b0; r.off = 32'h0; r.wd = 32'h0;
    r.rn = 1'b0; r.done = 1'b0; r.err = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(model_t s, logic v, logic [7:0] d, logic rl);
    model_t r;
    logic acc;
    int j;
    r   = s;
    acc = v && (s.st == M_HDR || s.st == M_RUN);
    r.we = 1'b0;
    r.rn = (s.st == M_DONE) && !rl;
    if (rl) begin
      r.st = M_HDR; r.pos = 0; r.idle = 0; r.x = 8'h00;
    end else if (acc) begin
      r.idle = 0;
      if (s.pos == 0) begin
        r.n = int'(d); r.x = 8'h00; r.st = M_RUN;
      end else if (s.pos == 1) begin
        r.n = s.n + 256 * int'(d);
        if (r.n == 0 || r.n > MAXW) r.st = M_ERR;
      end else if (s.pos < 2 + 4 * s.n) begin
        j = s.pos - 2;
        r.x = s.x ^ d;
        case (j % 4)
          0: r.b0 = d;
          1: r.b1 = d;
          2: r.b2 = d;
          default: begin
            r.we  = 1'b1;
            r.off = 32'(4 * (j / 4));
            r.wd  = {d, s.b2, s.b1, s.b0};
          end
        endcase
      end else begin
        r.st = (d == s.x) ? M_DONE : M_ERR;
      end
      r.pos = s.pos + 1;
    end else if (s.st == M_RUN) begin
      r.idle = s.idle + 1;
      if (r.idle == TO) r.st = M_ERR;
    end
    r.done = (r.st == M_DONE);
    r.err  = (r.st == M_ERR);
    return r;
  endfunction

  model_t m;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else          m <= model_step(m, rx_valid, rx_data, reload);
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    logic exp_ready;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        exp_ready = (m.st == M_HDR) || (m.st == M_RUN);
        chk("rx_ready0", 64'(rx_ready0), 64'(exp_ready));
        chk("rx_ready1", 64'(rx_ready1), 64'(exp_ready));
        chk("imem_we0", 64'(imem_we0), 64'(m.we));
        chk("imem_we1", 64'(imem_we1), 64'(m.we));
        chk("core_rn0", 64'(core_rn0), 64'(m.rn));
        chk("core_rn1", 64'(core_rn1), 64'(m.rn));
        chk("done0", 64'(done0), 64'(m.done));
        chk("done1", 64'(done1), 64'(m.done));
        chk("err0", 64'(err0), 64'(m.err));
        chk("err1", 64'(err1), 64'(m.err));
        if (m.st != M_HDR) begin
          chk("addr0", 64'(imem_addr0), 64'(m.off));
          chk("addr1", 64'(imem_addr1), 64'(32'h100 + m.off));
          chk("wdata0", 64'(imem_wdata0), 64'(m.wd));
          chk("wdata1", 64'(imem_wdata1), 64'(m.wd));
        end
      end
    end
  end

  // Write logger.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_we0) wlog0.push_back({imem_addr0, imem_wdata0});
      if (imem_we1) wlog1.push_back({imem_addr1, imem_wdata1});
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  task automatic chk_reset_vals();
    chk("rst_we0", 64'(imem_we0), 64'(0));
    chk("rst_addr0", 64'(imem_addr0), 64'(32'h0));
    chk("rst_addr1", 64'(imem_addr1), 64'(32'h100));
    chk("rst_wdata0", 64'(imem_wdata0), 64'(0));
    chk("rst_core_rn0", 64'(core_rn0), 64'(0));
    chk("rst_done0", 64'(done0), 64'(0));
    chk("rst_err0", 64'(err0), 64'(0));
  endtask

  // Two words 0x00100513, 0x00200593; XOR of the eight payload bytes is 0xB0.
  logic [7:0] hdr2[$]  = '{8'h02, 8'h00};
  logic [7:0] pay2[$]  = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
  int wbase;

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reload   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    chk("rst_ready0", 64'(rx_ready0), 64'(1));
    reset_n = 1'b1;
    idle(2);

    // Good frame.
    send_list(hdr2);
    send_list(pay2);
    idle(3);
    send(8'hB0);
    chk("A_done0", 64'(done0), 64'(1));
    chk("A_core_rn_same_cycle", 64'(core_rn0), 64'(0));
    idle(1);
    chk("A_core_rn_next", 64'(core_rn0), 64'(1));
    chk("A_core_rn1_next", 64'(core_rn1), 64'(1));
    chk("A_nwrites0", 64'(wlog0.size()), 64'(2));
    chk("A_w0_0", wlog0[0], {32'h0000_0000, 32'h0010_0513});
    chk("A_w0_1", wlog0[1], {32'h0000_0004, 32'h0020_0593});
    chk("A_w1_0", wlog1[0], {32'h0000_0100, 32'h0010_0513});
    chk("A_w1_1", wlog1[1], {32'h0000_0104, 32'h0020_0593});
    idle(2);

    // Reload from DONE.
    do_reload();
    chk("RL_core_rn0", 64'(core_rn0), 64'(0));
    chk("RL_done0", 64'(done0), 64'(0));
    chk("RL_ready0", 64'(rx_ready0), 64'(1));

    // Same frame, wrong checksum.
    wbase = wlog0.size();
    send_list(hdr2);
    send_list(pay2);
    send(8'h16);
    idle(2);
    chk("B_err0", 64'(err0), 64'(1));
    chk("B_core_rn0", 64'(core_rn0), 64'(0));
    chk("B_nwrites", 64'(wlog0.size() - wbase), 64'(2));

    // Reload with a byte in the same cycle: byte 0x05 is discarded, so the
    // following 00 00 header (N=0) is what gets rejected.
    do_reload();
    wbase = wlog0.size();
    reload   = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h05;
    @(posedge clk);
    #1;
    reload   = 1'b0;
    rx_valid = 1'b0;
    send(8'h00);
    send(8'h00);
    chk("C_zero_err0", 64'(err0), 64'(1));
    chk("C_zero_ready0", 64'(rx_ready0), 64'(0));
    idle(2);
    chk("C_zero_nwrites", 64'(wlog0.size() - wbase), 64'(0));

    // N = 257 exceeds MAX_WORDS.
    do_reload();
    send(8'h01);
    send(8'h01);
    chk("D_big_err0", 64'(err0), 64'(1));
    idle(2);

    // Stall after three payload bytes -> timeout, partial word never written.
    do_reload();
    wbase = wlog0.size();
    send(8'h01);
    send(8'h00);
    send(8'h13);
    send(8'h05);
    send(8'h10);
    idle(14);
    chk("E_no_err_yet", 64'(err0), 64'(0));
    idle(6);
    chk("E_timeout_err0", 64'(err0), 64'(1));
    chk("E_nwrites", 64'(wlog0.size() - wbase), 64'(0));

    // Asynchronous reset mid-frame after six payload bytes.
    do_reload();
    wbase = wlog0.size();
    send_list(hdr2);
    for (int i = 0; i < 6; i++) send(pay2[i]);
    chk("F_one_write", 64'(wlog0.size() - wbase), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);

    // Fresh frame after reset, with a 15-cycle gap that must not time out.
    wbase = wlog0.size();
    send_list(hdr2);
    send(pay2[0]);
    idle(15);
    for (int i = 1; i < 8; i++) send(pay2[i]);
    send(8'hB0);
    chk("G_done0", 64'(done0), 64'(1));
    idle(2);
    chk("G_nwrites", 64'(wlog0.size() - wbase), 64'(2));
    chk("G_w0", wlog0[wbase], {32'h0000_0000, 32'h0010_0513});
    chk("G_w1", wlog0[wbase + 1], {32'h0000_0004, 32'h0020_0593});
    chk("G_core_rn0", 64'(core_rn0), 64'(1));

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
